digit_scanner: RTL and testbench
================================

# digit_scanner

Time-multiplexing front end for a 4-digit common-anode/common-cathode seven-segment display. Holds a 16-bit hex value, scans one digit per time slot, and presents the selected nibble on `data` for the downstream `sevensegment` decoder together with a one-hot digit enable. New values are accepted through a valid/ready handshake into a staging register and become visible only at a frame boundary, so a displayed frame never mixes old and new digits. Optional leading-zero suppression and a per-slot blanking interval prevent ghosting.

## Interface

- `PRESCALE`, default 1000: clock cycles per digit slot; legal range is ≥ 2.
- `BLANK`, default 50: cycles at the start of each slot with all enables off; legal range is 0 ≤ BLANK < PRESCALE.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `value`  in  16  hex value to display; nibble i goes to digit i, with digit 0 the rightmost.
- `load_valid`  in  1  producer offers `value`.
- `load_ready`  out  1  staging register empty; a transfer occurs when `load_valid && load_ready`.
- `lz_blank`  in  1  leading-zero suppression enable; sampled live.
- `data`  out  4  nibble of the currently scanned digit; feeds `sevensegment.data`.
- `an`  out  4  one-hot digit enable, active-high; `4'b0000` means all digits dark.
- `frame_done`  out  1  one-cycle pulse on the last cycle of digit 3's slot.

## Operation

- **State:**
  - `pcnt`: slot counter, 0..PRESCALE-1.
  - `dig`: digit index, 0..3.
  - `disp[15:0]`: displayed value.
  - `stage[15:0]`: staging register.
  - `full`: staging register occupied.
- **Reset values** (asynchronous on `reset_n`=0):
  - pcnt=0, dig=0, disp=16'h0000, stage=16'h0000, full=0.
  - Outputs during reset: an=0000, data=0, frame_done=0, load_ready=1.
- **Counters:**
  - pcnt increments each cycle and wraps PRESCALE-1→0.
  - On that wrap, dig advances 0→1→2→3→0.
- **Outputs:** all combinational from registered state.
  - `data` = disp[4*dig+3 : 4*dig].
  - `frame_done` = (pcnt==PRESCALE-1) && (dig==3).
  - `load_ready` = !full.
- **Enable:** `an` = one-hot(dig) when pcnt ≥ BLANK and the digit is not suppressed; otherwise 0000.
- **Suppression:** digit i (i ≥ 1) is suppressed when lz_blank=1 and disp nibbles i..3 are all zero. Digit 0 is never suppressed. `data` is still driven for suppressed digits.
- **Handshake:**
  - On accept, `stage` ← `value` and full ← 1.
  - `value` is sampled only in the accept cycle.
- **Frame boundary** (edge ending the frame_done cycle): if full=1, disp ← stage and full ← 0.
- **Simultaneous accept and boundary:**
  - Accept is only possible when full=0, so no transfer happens on that edge.
  - The new value lands in `stage` and is displayed one full frame later.
- **Ordering:** the producer holding `load_valid` high against full=1 is stalled, not dropped. Exactly one value is accepted per ready window.
- **Reset mid-frame:** all state is discarded immediately, including a pending staged value. Scanning restarts at digit 0, pcnt=0.

## Timing

- Slot = PRESCALE cycles; frame = 4·PRESCALE cycles.
- Within a slot: BLANK cycles dark, then PRESCALE-BLANK cycles with the enable active.
- Load-to-display latency:
  - From an accept edge to the first cycle with the new disp: the remainder of the current frame.
  - Maximum: 4·PRESCALE cycles.
- `load_ready` rises in the cycle after the frame boundary that consumed `stage`.
- First frame after reset displays 0000.
- No output changes between clock edges except asynchronously on reset.

## Test plan

All scenarios use PRESCALE=4 and BLANK=1.

- **Reset and first frame:** release reset, hold load_valid=0 → frame_done pulses at cycles 15, 31, …; `an` sequence per slot is 0000, 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3; data=0 throughout.
- **Load latency:** with `value`=16'h1234, pulse load_valid at cycle 5 → accepted at cycle 5; load_ready=0 during cycles 6–15 and 1 from cycle 16; from cycle 16, data per slot is 4, 3, 2, 1 with the matching `an`.
- **Leading-zero suppression:** disp=16'h0070, lz_blank=1 → digit-3 and digit-2 slots have an=0000; digit 1 shows an=0010, data=7; digit 0 shows an=0001, data=0. With disp=16'h0000 only digit 0 lights. With lz_blank=0 all four digits light.
- **Back-pressure:** hold load_valid=1, with `value`=16'hAAAA at cycle 2 and changing to 16'hBBBB at cycle 3 → AAAA accepted at cycle 2; BBBB stalled until cycle 16 (ready=1) and accepted there; AAAA displayed in cycles 16–31, BBBB from cycle 32.
- **Boundary accept:** accept 16'h5555 exactly in the frame_done cycle (cycle 15) with full=0 → disp is unchanged at cycle 16; 5555 is displayed from cycle 32.
- **Reset mid-frame:** stage a value, then assert reset_n=0 during dig=2 → an=0000 and load_ready=1 immediately; after release, scanning restarts at digit 0 with disp=0000 and the staged value lost.

Source files
------------

// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexed front end for a 4-digit seven-segment display.
// Scans one nibble of the displayed value per slot and drives a one-hot,
// active-high digit enable. New values are staged and applied only at a frame
// boundary, so a frame never mixes digits from two different values.
module digit_scanner #(
  parameter int PRESCALE = 1000,  // clock cycles per digit slot, >= 2
  parameter int BLANK    = 50     // dark cycles at the start of each slot, < PRESCALE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        lz_blank,
  output logic [3:0]  data,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST_C  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BLANK_C = PW'(BLANK);

  // Handshake: a transfer happens on a rising edge where load_valid && load_ready.
  // load_ready is high exactly while the staging register is empty; value is
  // sampled only on the transfer edge, and a producer holding load_valid while
  // load_ready is low is stalled, never dropped.

  logic [PW-1:0] pcnt;
  logic [1:0]    dig;
  logic [15:0]   disp;
  logic [15:0]   stage;
  logic          full;

  logic          accept;
  logic          slot_last;
  logic [3:0]    sup;

  assign accept    = load_valid && !full;
  assign slot_last = (pcnt == LAST_C);

  // Slot counter and digit index: pcnt wraps each slot, dig advances on the wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      dig  <= 2'd0;
    end else if (slot_last) begin
      pcnt <= '0;
      dig  <= dig + 2'd1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Staging register and displayed value. Accept needs full=0 and the frame
  // boundary transfer needs full=1, so the two can never fire on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp  <= 16'h0000;
      stage <= 16'h0000;
      full  <= 1'b0;
    end else if (accept) begin
      stage <= value;
      full  <= 1'b1;
    end else if (frame_done && full) begin
      disp  <= stage;
      full  <= 1'b0;
    end
  end

  // Leading-zero suppression: digit i dims when it and every digit above it are
  // zero. Digit 0 always lights so a zero value still shows "0".
  always_comb begin
    sup    = 4'b0000;
    sup[1] = lz_blank && (disp[15:4]  == 12'h000);
    sup[2] = lz_blank && (disp[15:8]  == 8'h00);
    sup[3] = lz_blank && (disp[15:12] == 4'h0);
  end

  // Outputs derived purely from registered state (plus the live lz_blank).
  always_comb begin
    data       = disp[{dig, 2'b00} +: 4];
    frame_done = slot_last && (dig == 2'd3);
    load_ready = !full;
    an         = 4'b0000;
    if ((pcnt >= BLANK_C) && !sup[dig]) begin
      an = 4'b0001 << dig;
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: randomized and directed checks of digit_scanner against a
// cycle-count based reference model (PRESCALE=4, BLANK=1).
module tb_digit_scanner;

  localparam int P = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load_valid = 1'b0;
  logic        lz_blank = 1'b0;
  logic        load_ready;
  logic [3:0]  data;
  logic [3:0]  an;
  logic        frame_done;

  digit_scanner #(.PRESCALE(P), .BLANK(B)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .lz_blank   (lz_blank),
    .data       (data),
    .an         (an),
    .frame_done (frame_done)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position in the scan is derived from cycles since reset;
  // the pending queue holds at most one accepted-but-not-displayed value.
  int          cyc;
  logic [15:0] m_disp;
  logic [15:0] exp_q[$];
  logic [3:0]  exp_an;
  logic [3:0]  exp_data;
  logic        exp_fd;
  logic        exp_ready;

  function automatic void model_reset();
    cyc    = 0;
    m_disp = 16'h0000;
    exp_q.delete();
  endfunction

  // Wait to mid-cycle and compute what the outputs should be in this cycle.
  task automatic observe();
    int          d;
    int          pos;
    logic [15:0] upper;
    logic        lit;
    @(negedge clk);
    d         = (cyc / P) % 4;
    pos       = cyc % P;
    upper     = m_disp >> (4 * d);
    exp_data  = upper[3:0];
    lit       = (d == 0) || !lz_blank || (upper != 16'h0000);
    exp_an    = (pos >= B && lit) ? 4'(1 << d) : 4'b0000;
    exp_fd    = (pos == P - 1) && (d == 3);
    exp_ready = (exp_q.size() == 0);
  endtask

  // Cross the next rising edge and update the model with what happened on it.
  task automatic advance();
    logic        acc;
    logic        bnd;
    logic [15:0] v;
    acc = load_valid && (exp_q.size() == 0);
    v   = value;
    bnd = (cyc % (4 * P)) == (4 * P - 1);
    @(posedge clk);
    if (bnd && exp_q.size() > 0) m_disp = exp_q.pop_front();
    if (acc) exp_q.push_back(v);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    load_valid = 1'b0;
    value      = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_checks++; if (an !== 4'b0000) begin n_fail++; $display("FAIL rst_an got %b exp 0000", an); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", load_ready); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_fd got %b exp 0", frame_done); end
    n_checks++; if (data !== 4'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", data); end
    lz_blank = 1'b0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      observe();
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL first_an c=%0d got %b exp %b", c, an, exp_an); end
      n_checks++; if (data !== exp_data) begin n_fail++; $display("FAIL first_data c=%0d got %h exp %h", c, data, exp_data); end
      n_checks++; if (frame_done !== exp_fd) begin n_fail++; $display("FAIL first_fd c=%0d got %b exp %b", c, frame_done, exp_fd); end
      if (c == 15 || c == 31) begin
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL fd_pulse c=%0d got %b exp 1", c, frame_done); end
      end
      if (c == 1) begin
        n_checks++; if (an !== 4'b0001) begin n_fail++; $display("FAIL first_slot_an c=%0d got %b exp 0001", c, an); end
      end
      if (c == 12) begin
        n_checks++; if (an !== 4'b0000) begin n_fail++; $display("FAIL blank_an c=%0d got %b exp 0000", c, an); end
      end
      advance();
    end
  endtask

  task automatic test_load_latency();
    lz_blank = 1'b0;
    do_reset();
    value = 16'h1234;
    for (int c = 0; c < 48; c++) begin
      load_valid = (c == 5);
      observe();
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL lat_an c=%0d got %b exp %b", c, an, exp_an); end
      n_checks++; if (data !== exp_data) begin n_fail++; $display("FAIL lat_data c=%0d got %h exp %h", c, data, exp_data); end
      n_checks++; if (load_ready !== exp_ready) begin n_fail++; $display("FAIL lat_ready c=%0d got %b exp %b", c, load_ready, exp_ready); end
      if (c == 6 || c == 15) begin
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL lat_stall c=%0d got %b exp 0", c, load_ready); end
      end
      if (c == 16) begin
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL lat_rise c=%0d got %b exp 1", c, load_ready); end
      end
      if (c == 17) begin
        n_checks++; if (data !== 4'h4 || an !== 4'b0001) begin n_fail++; $display("FAIL lat_dig0 c=%0d got %h/%b exp 4/0001", c, data, an); end
      end
      if (c == 29) begin
        n_checks++; if (data !== 4'h1 || an !== 4'b1000) begin n_fail++; $display("FAIL lat_dig3 c=%0d got %h/%b exp 1/1000", c, data, an); end
      end
      advance();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_lz();
    do_reset();
    value = 16'h0070;
    for (int c = 0; c < 48; c++) begin
      load_valid = (c == 0);
      lz_blank   = (c < 32);
      observe();
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL lz_an c=%0d got %b exp %b", c, an, exp_an); end
      n_checks++; if (data !== exp_data) begin n_fail++; $display("FAIL lz_data c=%0d got %h exp %h", c, data, exp_data); end
      if (c == 5 || c == 25 || c == 29) begin
        n_checks++; if (an !== 4'b0000) begin n_fail++; $display("FAIL lz_dark c=%0d got %b exp 0000", c, an); end
      end
      if (c == 3 || c == 17) begin
        n_checks++; if (an !== 4'b0001 || data !== 4'h0) begin n_fail++; $display("FAIL lz_dig0 c=%0d got %b/%h exp 0001/0", c, an, data); end
      end
      if (c == 21) begin
        n_checks++; if (an !== 4'b0010 || data !== 4'h7) begin n_fail++; $display("FAIL lz_dig1 c=%0d got %b/%h exp 0010/7", c, an, data); end
      end
      if (c == 45) begin
        n_checks++; if (an !== 4'b1000) begin n_fail++; $display("FAIL lz_off c=%0d got %b exp 1000", c, an); end
      end
      advance();
    end
    load_valid = 1'b0;
    lz_blank   = 1'b0;
  endtask

  task automatic test_back_pressure();
    lz_blank = 1'b0;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      load_valid = (c >= 2 && c <= 16);
      value      = (c <= 2) ? 16'hAAAA : 16'hBBBB;
      observe();
      n_checks++; if (data !== exp_data) begin n_fail++; $display("FAIL bp_data c=%0d got %h exp %h", c, data, exp_data); end
      n_checks++; if (load_ready !== exp_ready) begin n_fail++; $display("FAIL bp_ready c=%0d got %b exp %b", c, load_ready, exp_ready); end
      if (c == 10) begin
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall c=%0d got %b exp 0", c, load_ready); end
      end
      if (c == 17) begin
        n_checks++; if (data !== 4'hA) begin n_fail++; $display("FAIL bp_first c=%0d got %h exp a", c, data); end
      end
      if (c == 33) begin
        n_checks++; if (data !== 4'hB) begin n_fail++; $display("FAIL bp_second c=%0d got %h exp b", c, data); end
      end
      advance();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_boundary_accept();
    lz_blank = 1'b0;
    do_reset();
    value = 16'h5555;
    for (int c = 0; c < 48; c++) begin
      load_valid = (c == 15);
      observe();
      n_checks++; if (data !== exp_data) begin n_fail++; $display("FAIL ba_data c=%0d got %h exp %h", c, data, exp_data); end
      n_checks++; if (load_ready !== exp_ready) begin n_fail++; $display("FAIL ba_ready c=%0d got %b exp %b", c, load_ready, exp_ready); end
      if (c == 17) begin
        n_checks++; if (data !== 4'h0) begin n_fail++; $display("FAIL ba_unchanged c=%0d got %h exp 0", c, data); end
      end
      if (c == 33) begin
        n_checks++; if (data !== 4'h5) begin n_fail++; $display("FAIL ba_shown c=%0d got %h exp 5", c, data); end
      end
      advance();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    lz_blank = 1'b0;
    do_reset();
    value = 16'h9876;
    for (int c = 0; c < 10; c++) begin
      load_valid = (c == 1);
      observe();
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL mid_an c=%0d got %b exp %b", c, an, exp_an); end
      advance();
    end
    load_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if (an !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_an got %b exp 0000", an); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 1", load_ready); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 32; c++) begin
      observe();
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL mid_post_an c=%0d got %b exp %b", c, an, exp_an); end
      n_checks++; if (data !== exp_data) begin n_fail++; $display("FAIL mid_post_data c=%0d got %h exp %h", c, data, exp_data); end
      if (c == 17) begin
        n_checks++; if (data !== 4'h0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_lost c=%0d got %h/%b exp 0/1", c, data, load_ready); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 480; c++) begin
      if (c % 8 == 0) lz_blank = ($urandom_range(0, 1) == 1);
      load_valid = ($urandom_range(0, 3) == 0);
      value      = ($urandom_range(0, 3) == 0) ? 16'(($urandom_range(0, 15)) << (4 * $urandom_range(0, 3))) : 16'($urandom);
      observe();
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL rnd_an c=%0d got %b exp %b", c, an, exp_an); end
      n_checks++; if (data !== exp_data) begin n_fail++; $display("FAIL rnd_data c=%0d got %h exp %h", c, data, exp_data); end
      n_checks++; if (frame_done !== exp_fd) begin n_fail++; $display("FAIL rnd_fd c=%0d got %b exp %b", c, frame_done, exp_fd); end
      n_checks++; if (load_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, load_ready, exp_ready); end
      advance();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_latency();
    test_lz();
    test_back_pressure();
    test_boundary_accept();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
